// File: rtl/seg_scan_mux_if.sv
// Connects the datapath digit registers to the seven-segment scanner.
// The pin-side results come back on the same bundle.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_suppress;

  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;

  modport master (
    output enable, digits, dp_in, blank_in, lz_suppress,
    input  seg, dp, an, digit_idx
  );

  modport slave (
    input  enable, digits, dp_in, blank_in, lz_suppress,
    output seg, dp, an, digit_idx
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: refresh prescaler, digit scan, hex decode,
// frame-coherent shadow registers, blanking/leading-zero suppression and anode guard time.
module seg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic          clk,
  input logic          rst_n,
  seg_scan_mux_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    sh_lz;

  logic                    frame_start;
  logic                    upper_zero;
  logic                    dark;
  logic [3:0]              nibble;
  logic [6:0]              seg_on;
  logic                    dp_on;
  logic [NUM_DIGITS-1:0]   an_on;

  logic [6:0]              seg_d, seg_q;
  logic                    dp_d, dp_q;
  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [IDX_W-1:0]        idx_d, idx_q;

  function automatic logic [6:0] hex_to_seg_al(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

  assign frame_start = bus.enable && (cnt == '0) && (idx == '0);

  // Dropping enable parks the scan so re-enabling always restarts a fresh frame at digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!bus.enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Inputs are sampled once per frame so a scan never mixes old and new digit values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_lz     <= 1'b0;
    end else if (frame_start) begin
      sh_digits <= bus.digits;
      sh_dp     <= bus.dp_in;
      sh_blank  <= bus.blank_in;
      sh_lz     <= bus.lz_suppress;
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (sh_digits[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Polarity is applied last by XOR with the "off" pattern; a disabled display is all off.
  always_comb begin
    nibble = sh_digits[4*idx +: 4];
    dark   = sh_blank[idx] | (sh_lz & (idx != '0) & upper_zero);
    seg_on = '0;
    dp_on  = 1'b0;
    an_on  = '0;
    idx_d  = '0;
    if (bus.enable) begin
      seg_on = dark ? 7'h00 : ~hex_to_seg_al(nibble);
      dp_on  = ~dark & sh_dp[idx];
      an_on  = (cnt < CNT_GUARD) ? '0 : (NUM_DIGITS'(1) << idx);
      idx_d  = idx;
    end
    seg_d = seg_on ^ SEG_OFF;
    dp_d  = dp_on ^ DP_OFF;
    an_d  = an_on ^ AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
      idx_q <= '0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      idx_q <= idx_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = idx_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a cycle model queues the expected pin state every clock,
// and directed checks cover reset, latency, frame coherency, blanking and enable drop.
module tb_seg_scan_mux;
  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int GD  = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycles;
  int   active;

  exp_t exp_q[$];
  exp_t exp_now;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int         m_cnt;
  int         m_idx;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic        m_lz;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(DIV),
    .GUARD(GD),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                               input logic [3:0] blank, input logic lz);
    bus.digits      = d;
    bus.dp_in       = dpv;
    bus.blank_in    = blank;
    bus.lz_suppress = lz;
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int budget = 200;
    while (bus.an !== target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (bus.an !== target) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_frame_start();
    wait_an(4'b0111, "frame_last");
    wait_an(4'b1110, "frame_first");
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic dark;
    dark  = m_blank[m_idx] || (m_lz && m_idx > 0 && ((m_digits >> (4 * m_idx)) == 16'h0));
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.idx = 2'd0;
    if (bus.enable) begin
      e.an  = (m_cnt < GD) ? 4'hF : ~(4'b0001 << m_idx);
      e.seg = dark ? 7'h7F : seg_tab[m_digits[4*m_idx +: 4]];
      e.dp  = dark ? 1'b1 : ~m_dp[m_idx];
      e.idx = 2'(m_idx);
    end
    return e;
  endfunction

  // Reference scanner: expected pins for the next cycle are queued at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt    <= 0;
      m_idx    <= 0;
      m_digits <= '0;
      m_dp     <= '0;
      m_blank  <= '0;
      m_lz     <= 1'b0;
    end else begin
      exp_q.push_back(model_out());
      if (!bus.enable) begin
        m_cnt <= 0;
        m_idx <= 0;
      end else begin
        if (m_cnt == 0 && m_idx == 0) begin
          m_digits <= bus.digits;
          m_dp     <= bus.dp_in;
          m_blank  <= bus.blank_in;
          m_lz     <= bus.lz_suppress;
        end
        if (m_cnt == DIV - 1) begin
          m_cnt <= 0;
          m_idx <= (m_idx + 1) % ND;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
      checkOutput("an", 32'(bus.an), 32'(exp_now.an));
      checkOutput("seg", 32'(bus.seg), 32'(exp_now.seg));
      checkOutput("dp", 32'(bus.dp), 32'(exp_now.dp));
      checkOutput("digit_idx", 32'(bus.digit_idx), 32'(exp_now.idx));
      checkOutput("one_anode", 32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  initial begin
    bus.enable = 1'b0;
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("reset_an", 32'(bus.an), 32'hF);
    checkOutput("reset_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    applyStimulus(16'h1234, 4'b0100, 4'b0000, 1'b0);

    // Scenario 1: asynchronous reset in the middle of an active slot.
    wait_an(4'b1110, "s1_active");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("s1_async_an", 32'(bus.an), 32'hF);
    checkOutput("s1_async_seg", 32'(bus.seg), 32'h7F);
    checkOutput("s1_async_dp", 32'(bus.dp), 32'h1);
    checkOutput("s1_async_idx", 32'(bus.digit_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.an !== 4'b1110 && cycles < 20);
    checkOutput("s1_first_an_latency", 32'(cycles), 32'd3);

    // Scenario 2: 1234 with a decimal point on digit 2; slot length and frame period.
    checkOutput("s2_d0_seg", 32'(bus.seg), 32'b0011001);
    active = 0;
    cycles = 0;
    while (bus.an === 4'b1110 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      active++;
    end
    while (bus.an !== 4'b1110 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("s2_active_cycles", 32'(active), 32'd6);
    checkOutput("s2_frame_period", 32'(cycles), 32'd32);
    wait_an(4'b1101, "s2_d1");
    checkOutput("s2_d1_seg", 32'(bus.seg), 32'b0110000);
    wait_an(4'b1011, "s2_d2");
    checkOutput("s2_d2_seg", 32'(bus.seg), 32'b0100100);
    checkOutput("s2_d2_dp", 32'(bus.dp), 32'd0);
    wait_an(4'b0111, "s2_d3");
    checkOutput("s2_d3_seg", 32'(bus.seg), 32'b1111001);
    checkOutput("s2_d3_dp", 32'(bus.dp), 32'd1);
    repeat (20) @(negedge clk);

    // Scenario 3: leading-zero suppression on and off.
    applyStimulus(16'h00A0, 4'b0000, 4'b0000, 1'b1);
    wait_frame_start();
    checkOutput("s3_d0_seg", 32'(bus.seg), 32'b1000000);
    wait_an(4'b1101, "s3_d1");
    checkOutput("s3_d1_seg", 32'(bus.seg), 32'b0001000);
    wait_an(4'b1011, "s3_d2");
    checkOutput("s3_d2_dark_seg", 32'(bus.seg), 32'h7F);
    wait_an(4'b0111, "s3_d3");
    checkOutput("s3_d3_dark_seg", 32'(bus.seg), 32'h7F);
    checkOutput("s3_d3_dark_dp", 32'(bus.dp), 32'd1);
    applyStimulus(16'h00A0, 4'b0000, 4'b0000, 1'b0);
    wait_frame_start();
    wait_an(4'b1011, "s3b_d2");
    checkOutput("s3b_d2_seg", 32'(bus.seg), 32'b1000000);
    wait_an(4'b0111, "s3b_d3");
    checkOutput("s3b_d3_seg", 32'(bus.seg), 32'b1000000);

    // Scenario 4: input change mid-frame only lands at the next frame.
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    wait_frame_start();
    wait_an(4'b1011, "s4_d2");
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("s4_d2_old", 32'(bus.seg), 32'b1111001);
    wait_an(4'b0111, "s4_d3");
    checkOutput("s4_d3_old", 32'(bus.seg), 32'b1111001);
    wait_an(4'b1110, "s4_next");
    checkOutput("s4_d0_new", 32'(bus.seg), 32'b0100100);
    wait_an(4'b0111, "s4_next_d3");
    checkOutput("s4_d3_new", 32'(bus.seg), 32'b0100100);

    // Scenario 5: forced blanking of digit 1 with all decimal points lit.
    applyStimulus(16'h8888, 4'b1111, 4'b0010, 1'b0);
    wait_frame_start();
    checkOutput("s5_d0_seg", 32'(bus.seg), 32'h00);
    checkOutput("s5_d0_dp", 32'(bus.dp), 32'd0);
    wait_an(4'b1101, "s5_d1");
    checkOutput("s5_d1_seg", 32'(bus.seg), 32'h7F);
    checkOutput("s5_d1_dp", 32'(bus.dp), 32'd1);
    wait_an(4'b1011, "s5_d2");
    checkOutput("s5_d2_seg", 32'(bus.seg), 32'h00);
    checkOutput("s5_d2_dp", 32'(bus.dp), 32'd0);

    // Scenario 6: one-cycle enable drop at digit 2, then a fresh frame at digit 0.
    wait_frame_start();
    wait_an(4'b1011, "s6_d2");
    bus.enable = 1'b0;
    applyStimulus(16'h5555, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("s6_off_an", 32'(bus.an), 32'hF);
    checkOutput("s6_off_seg", 32'(bus.seg), 32'h7F);
    checkOutput("s6_off_dp", 32'(bus.dp), 32'd1);
    checkOutput("s6_off_idx", 32'(bus.digit_idx), 32'd0);
    bus.enable = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.an !== 4'b1110 && cycles < 20);
    checkOutput("s6_restart_latency", 32'(cycles), 32'd3);
    checkOutput("s6_fresh_shadow", 32'(bus.seg), 32'b0010010);
    checkOutput("s6_restart_idx", 32'(bus.digit_idx), 32'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
